cla_div_seq: RTL and testbench
==============================

// Module: cla_div_seq
// PURPOSE
//   Multi-cycle 32-bit integer divider: restoring division, one quotient bit per clock.
//   Every trial subtraction goes through one shared 32-bit `cla` instance
//   (a, b = ~divisor, cin = 1); this block owns the FSM, shift registers and handshakes.
//   Sits beside the ALU in the execute stage as the long-latency DIV/REM unit.
// PARAMETERS
//   WIDTH  32  operand/result width; only 32 is legal (fixed by `cla`), else $error at elaboration
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   i_valid      in   1   request valid
//   o_ready      out  1   request accepted when i_valid & o_ready
//   i_dividend   in   32  dividend, sampled at accept only
//   i_divisor    in   32  divisor, sampled at accept only
//   i_signed     in   1   signed op (present only with CLA_DIV_SIGNED_EN)
//   o_valid      out  1   result valid
//   i_ready      in   1   result consumed when o_valid & i_ready
//   o_quotient   out  32  quotient
//   o_remainder  out  32  remainder
//   o_divzero    out  1   divisor was zero (qualified by o_valid)
// BEHAVIOUR
//   Reset (async assert): state=IDLE, o_valid=0, o_ready=1, o_quotient=0, o_remainder=0, o_divzero=0.
//   States: IDLE -> BUSY | DONE; BUSY -> DONE; DONE -> IDLE.
//   IDLE: o_ready=1. Accept: latch operands; divisor==0 -> DONE (q=32'hFFFFFFFF,
//     r=dividend, o_divzero=1); else rem=0, quo=dividend, cnt=31, -> BUSY.
//   BUSY: o_ready=0; i_valid ignored. Per cycle: a={rem[30:0],quo[31]};
//     s=cla(a,~div,1); cout=maj(a[31],~div[31],s[31]^a[31]^~div[31]);
//     ge=rem[31]|cout; rem<=ge?s:a; quo<={quo[30:0],ge}; cnt<=cnt-1; cnt==0 -> DONE.
//   DONE: o_valid=1, o_ready=0; outputs held stable until i_ready; on handshake -> IDLE,
//     o_valid=0 next cycle. No accept in the handshake cycle (min 1 IDLE cycle between ops).
//   Latency (accept edge = T): o_valid at T+33 normal, T+1 divide-by-zero.
//   Throughput: one op per 34 cycles with i_ready held high.
//   o_quotient/o_remainder/o_divzero only change on DONE entry; zero-ness of an
//     unsigned 32-bit result is unconditional (no overflow case).
//   Reset mid-BUSY/DONE: op discarded, all reset values restored; no partial result emitted.
// CONFIGURATION
//   CLA_DIV_SIGNED_EN defined: i_signed port exists. If i_signed=1, operands converted
//     to magnitudes at accept; quotient negated when signs differ, remainder takes
//     dividend sign (truncating). Negation done at accept/DONE entry, no extra cycles.
//     Div-by-zero: q=32'hFFFFFFFF, r=dividend. 32'h80000000/-1: q=32'h80000000, r=0,
//     o_divzero=0, normal latency.
//   Undefined: no i_signed port; all operations unsigned.
// TESTING
//   100/7 unsigned -> o_valid exactly 33 cycles after accept, q=14, r=2, o_divzero=0.
//   32'h1234/0 -> o_valid at T+1, q=32'hFFFFFFFF, r=32'h1234, o_divzero=1.
//   32'hFFFFFFFF/1 -> q=32'hFFFFFFFF, r=0; 32'h80000000/32'hFFFFFFFF -> q=0, r=32'h80000000.
//   i_ready low 5 cycles in DONE + i_valid high throughout -> outputs stable, o_ready=0, no accept.
//   rst_n low at iteration 10 -> o_valid=0, o_ready=1 immediately; next 100/7 gives q=14, r=2.
//   CLA_DIV_SIGNED_EN: -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; 32'h80000000/-1 -> q=32'h80000000, r=0.

Source files
------------

// File: rtl/cla_div_seq.sv
// Sequential restoring divider: one quotient bit per clock through a shared 32-bit CLA.
// Optional signed support is compiled in with `define CLA_DIV_SIGNED_EN.
`timescale 1ns/1ps

module cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  gc;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;

  // Two-level lookahead: 4-bit groups, group carries chained from the group G/P terms.
  // NOTE: every variable written in an always_comb gets a value on every path; a
  // missing default on any path would infer a latch.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    gc    = '0;
    grp_g = '0;
    grp_p = '0;
    gc[0] = cin;
    for (int i = 0; i < 8; i++) begin
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];
      gc[i+1]  = grp_g[i] | (grp_p[i] & gc[i]);
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
    s = p ^ c;
  end
endmodule

module cla_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
`ifdef CLA_DIV_SIGNED_EN
  input  logic             i_signed,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_divzero
);

  if (WIDTH != 32) begin : g_width_check
    $error("cla_div_seq: WIDTH must be 32");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        o_valid_q, o_valid_d;
  logic        o_ready_q, o_ready_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        divzero_q, divzero_d;

  logic        op_signed;
  logic [31:0] mag_dividend;
  logic [31:0] mag_divisor;
  logic [31:0] cla_a;
  logic [31:0] cla_b;
  logic [31:0] cla_s;
  logic        carry_31;
  logic        cout;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

`ifdef CLA_DIV_SIGNED_EN
  assign op_signed = i_signed;
`else
  assign op_signed = 1'b0;
`endif

  assign mag_dividend = (op_signed && i_dividend[31]) ? (32'd0 - i_dividend) : i_dividend;
  assign mag_divisor  = (op_signed && i_divisor[31])  ? (32'd0 - i_divisor)  : i_divisor;

  // Trial subtraction a - div computed as a + ~div + 1 on the shared adder.
  assign cla_a = {rem_q[30:0], quo_q[31]};
  assign cla_b = ~div_q;

  cla u_cla (
    .a   (cla_a),
    .b   (cla_b),
    .cin (1'b1),
    .s   (cla_s)
  );

  // Carry out recovered from the sum bit; rem_q[31] is the 33rd bit of the shifted remainder.
  assign carry_31 = cla_s[31] ^ cla_a[31] ^ cla_b[31];
  assign cout     = (cla_a[31] & cla_b[31]) | (cla_a[31] & carry_31) | (cla_b[31] & carry_31);
  assign ge       = rem_q[31] | cout;
  assign rem_step = ge ? cla_s : cla_a;
  assign quo_step = {quo_q[30:0], ge};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    o_valid_d   = o_valid_q;
    o_ready_d   = o_ready_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          o_ready_d = 1'b0;
          div_d     = mag_divisor;
          neg_quo_d = op_signed & (i_dividend[31] ^ i_divisor[31]);
          neg_rem_d = op_signed & i_dividend[31];
          if (i_divisor == 32'd0) begin
            state_d     = DONE;
            o_valid_d   = 1'b1;
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = i_dividend;
            divzero_d   = 1'b1;
          end else begin
            state_d = BUSY;
            rem_d   = 32'd0;
            quo_d   = mag_dividend;
            cnt_d   = 5'd31;
          end
        end
      end
      BUSY: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          // Last iteration lands directly in the output registers with sign fix-up applied.
          state_d     = DONE;
          o_valid_d   = 1'b1;
          quotient_d  = neg_quo_q ? (32'd0 - quo_step) : quo_step;
          remainder_d = neg_rem_q ? (32'd0 - rem_step) : rem_step;
          divzero_d   = 1'b0;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d   = IDLE;
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
        o_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering. Datapath registers are reset too,
  // so a reset mid-operation leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      div_q       <= 32'd0;
      cnt_q       <= 5'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_ready_q   <= 1'b1;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      o_valid_q   <= o_valid_d;
      o_ready_q   <= o_ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
    end
  end

  assign o_valid     = o_valid_q;
  assign o_ready     = o_ready_q;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;
  assign o_divzero   = divzero_q;

endmodule

// File: tb/tb_cla_div_seq.sv
// Scoreboard bench for cla_div_seq: driver pushes expected results, monitor pops on o_valid.
// Latency = rising edges from the accepting edge to the first edge that samples o_valid high.
`timescale 1ns/1ps

module tb_cla_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        i_signed_r = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_divzero;

  always #5 clk = ~clk;

  cla_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
`ifdef CLA_DIV_SIGNED_EN
    .i_signed    (i_signed_r),
`endif
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_divzero   (o_divzero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    time         t_acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares the first cycle of each result, then checks it holds while stalled.
  initial begin : monitor
    logic        in_res;
    logic [31:0] hq, hr;
    logic        hdz;
    exp_t        e;
    in_res = 1'b0;
    hq = '0; hr = '0; hdz = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (!in_res) begin
          in_res = 1'b1;
          hq = o_quotient; hr = o_remainder; hdz = o_divzero;
          check("ready_in_done", {31'd0, o_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_result", {31'd0, o_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("quotient", o_quotient, e.q);
            check("remainder", o_remainder, e.r);
            check("divzero", {31'd0, o_divzero}, {31'd0, e.dz});
            check("latency", 32'(($time + 5 - e.t_acc) / 10), 32'(e.lat));
          end
        end else begin
          check("hold_quotient", o_quotient, hq);
          check("hold_remainder", o_remainder, hr);
          check("hold_divzero", {31'd0, o_divzero}, {31'd0, hdz});
          check("hold_ready", {31'd0, o_ready}, 32'd0);
        end
      end else begin
        in_res = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       output time t_acc);
    int   budget;
    exp_t e;
    budget = 0;
    t_acc  = 0;
    @(negedge clk);
    i_dividend = a; i_divisor = b; i_signed_r = sg; i_valid = 1'b1;
    while (o_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (o_ready !== 1'b1) begin
      check("accept_timeout", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc   = $time;
    e.q     = eq;
    e.r     = er;
    e.dz    = edz;
    e.lat   = edz ? 1 : 33;
    e.t_acc = $time;
    exp_q.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    vec_t vecs[$];
    time  t1, t2;
    int   budget;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    vecs.push_back('{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0});
    vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0});
    vecs.push_back('{32'd1000000,    32'd3,          1'b0, 32'd333333,     32'd1,          1'b0});
    vecs.push_back('{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0});
    vecs.push_back('{32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b1});
    vecs.push_back('{32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 32'd1,          32'h7FFF_FFFE,  1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0});
`ifdef CLA_DIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1});
`endif

    // Reset state, both while held and after release.
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_quotient", o_quotient, 32'd0);
    check("rst_remainder", o_remainder, 32'd0);
    check("rst_divzero", {31'd0, o_divzero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, o_ready}, 32'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].q, vecs[i].r, vecs[i].dz, t1);
      drain();
    end

    // Back-to-back with i_ready high: one op every 34 cycles.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, t1);
    issue(32'd1000000, 32'd3, 1'b0, 32'd333333, 32'd1, 1'b0, t2);
    check("throughput", 32'((t2 - t1) / 10), 32'd34);
    drain();

    // Stall in DONE for 5 cycles with a competing request held on i_valid.
    i_ready = 1'b0;
    issue(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, t1);
    i_dividend = 32'd5; i_divisor = 32'd1; i_valid = 1'b1;
    budget = 0;
    while (o_valid !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("stall_reach_done", {31'd0, o_valid}, 32'd1);
    repeat (5) @(negedge clk);
    i_ready = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    check("post_hs_valid", {31'd0, o_valid}, 32'd0);
    check("post_hs_ready", {31'd0, o_ready}, 32'd1);
    drain();

    // Reset around iteration 10 discards the op.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, t1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    check("midrst_quotient", o_quotient, 32'd0);
    check("midrst_remainder", o_remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, t1);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
